tmr32_alarm_sched: RTL

- APB-programmable alarm scheduler that shares one TIMER32 compare/overflow resource among NCH software alarm channels.
- The TIMER32 core is free-running; TMR is the current tick count, scaled by PRE.
- The scheduler holds an absolute 32-bit deadline per channel and loads the earliest armed deadline into TMRCMP.
- On TMROV it marks that channel pending, clears the overflow, then rescans. It sits on the APB bus in place of the plain timer register wrapper.

---
 rtl/tmr32_alarm_sched.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tmr32_alarm_sched.sv
// -----------------------------------------------------------------------------
// tmr32_alarm_sched
//
// APB alarm scheduler that shares one TIMER32 compare/overflow resource among
// NCH software alarm channels. Each channel holds an absolute 32-bit deadline.
// The earliest armed deadline (by distance from the current TMR count, modulo
// 2^32) is loaded into TMRCMP. When the core reports the match, that channel is
// marked pending and the channels are rescanned.
//
// Build option: define TMR32_SCHED_PERIODIC_EN to add per-channel PERIOD
// registers (0x80+4i) that re-arm a channel at DEADLINE+PERIOD on every fire.
//
// Ports
//   PCLK, PRESETn          APB clock, async active-low reset
//   PSEL/PENABLE/PWRITE    APB control; writes on PSEL&PWRITE&PENABLE
//   PADDR[19:2], PWDATA    APB word address / write data
//   PRDATA, PREADY         combinational read data (on PADDR), always ready
//   IRQ                    OR of PEND & IRQEN
//   TMR, TMROV             count and sticky compare-match flag from the core
//   PRE, TMRCMP            prescaler and compare value to the core
//   TMROVCLR, TMREN        overflow clear pulse and compare enable to the core
//
// Register map (byte offsets)
//   0x00 CTRL[0]=GEN   0x04 PRE   0x08 ARM   0x0C PEND (W1C)   0x10 IRQEN
//   0x14 TMR (ro)      0x40+4i DEADLINE[i] (write also arms)   0x80+4i PERIOD[i]
//   unmapped reads return 0xDEADBEEF
//
// FSM states
//   state  | meaning
//   IDLE   | compare disabled, waiting for GEN & dirty
//   SCAN   | one channel per cycle: fire expired, track nearest future deadline
//   LOAD   | drive TMRCMP with the nearest deadline, pulse TMROVCLR
//   WAIT   | compare armed; TMROV fires current channel, dirty forces rescan
// -----------------------------------------------------------------------------
module tmr32_alarm_sched #(
    parameter int NCH = 4
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic [19:2] PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        IRQ,
    input  logic [31:0] TMR,
    input  logic        TMROV,
    output logic [31:0] PRE,
    output logic [31:0] TMRCMP,
    output logic        TMROVCLR,
    output logic        TMREN
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    logic [1:0]     state;
    logic           gen;
    logic           dirty;
    logic [NCH-1:0] arm;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] irqen;
    logic [31:0]    pre_q;
    logic [31:0]    deadline [NCH];
    logic [IW-1:0]  idx;
    logic [IW-1:0]  best;
    logic [IW-1:0]  cur;
    logic           best_vld;
    logic [31:0]    best_dist;
    logic [31:0]    cmp_q;
    logic           en_q;

    logic [17:0]    wa;
    logic           wr_en;
    logic           wr_ctrl;
    logic           wr_pre;
    logic           wr_arm;
    logic           wr_pend;
    logic           wr_irqen;
    logic [NCH-1:0] wr_dl;
    logic [31:0]    scan_dl;
    logic [31:0]    scan_dist;
    logic           scan_arm;
    logic           scan_exp;
    logic           scan_cand;
    logic           last_idx;
    logic           fire_en;
    logic [IW-1:0]  fire_idx;
    logic           reload;
    logic [31:0]    reload_dl;
    logic           enter_scan;

    assign wa       = PADDR;
    assign wr_en    = PSEL & PWRITE & PENABLE;
    assign wr_ctrl  = wr_en & (wa == 18'h0);
    assign wr_pre   = wr_en & (wa == 18'h1);
    assign wr_arm   = wr_en & (wa == 18'h2);
    assign wr_pend  = wr_en & (wa == 18'h3);
    assign wr_irqen = wr_en & (wa == 18'h4);

    always_comb begin
        wr_dl = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_dl[i] = wr_en & (wa == 18'(16 + i));
        end
    end

    // Distance is taken modulo 2^32 so deadlines across the TMR wrap still
    // order correctly; anything at or behind TMR counts as expired.
    assign scan_dl   = deadline[idx];
    assign scan_arm  = arm[idx];
    assign scan_dist = scan_dl - TMR;
    assign scan_exp  = (scan_dist == 32'd0) | scan_dist[31];
    assign scan_cand = scan_arm & ~scan_exp & (~best_vld | (scan_dist < best_dist));
    assign last_idx  = (idx == IW'(NCH - 1));

    always_comb begin
        fire_en  = 1'b0;
        fire_idx = idx;
        if (gen && (state == S_SCAN) && scan_arm && scan_exp) begin
            fire_en = 1'b1;
        end else if (gen && (state == S_WAIT) && TMROV) begin
            fire_en  = 1'b1;
            fire_idx = cur;
        end
    end

    assign enter_scan = gen & (((state == S_IDLE) & dirty) |
                               ((state == S_WAIT) & (TMROV | dirty)));

`ifdef TMR32_SCHED_PERIODIC_EN
    logic [31:0]    period [NCH];
    logic [NCH-1:0] wr_pd;

    always_comb begin
        wr_pd = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_pd[i] = wr_en & (wa == 18'(32 + i));
        end
    end

    assign reload    = fire_en & (period[fire_idx] != 32'd0);
    assign reload_dl = deadline[fire_idx] + period[fire_idx];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NCH; i++) period[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_pd[i]) period[i] <= PWDATA;
            end
        end
    end
`else
    assign reload    = 1'b0;
    assign reload_dl = 32'd0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            gen   <= 1'b0;
            pre_q <= '0;
            irqen <= '0;
        end else begin
            if (wr_ctrl)  gen   <= PWDATA[0];
            if (wr_pre)   pre_q <= PWDATA;
            if (wr_irqen) irqen <= PWDATA[NCH-1:0];
        end
    end

    // Write beats clear so a config change landing on the SCAN entry edge is
    // not lost. A periodic reload during SCAN also requests a rescan so the
    // re-armed channel gets considered.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            dirty <= 1'b0;
        end else if (wr_ctrl | wr_arm | (|wr_dl) | (reload & (state == S_SCAN))) begin
            dirty <= 1'b1;
        end else if (enter_scan) begin
            dirty <= 1'b0;
        end
    end

    // Fire is applied first so a same-cycle APB write to ARM/DEADLINE wins
    // over the disarm, while PEND set beats a same-cycle W1C.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            arm  <= '0;
            pend <= '0;
            for (int i = 0; i < NCH; i++) deadline[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (fire_en && (fire_idx == IW'(i))) begin
                    pend[i] <= 1'b1;
                    if (reload) deadline[i] <= reload_dl;
                    else        arm[i]      <= 1'b0;
                end else if (wr_pend && PWDATA[i]) begin
                    pend[i] <= 1'b0;
                end
                if (wr_arm) arm[i] <= PWDATA[i];
                if (wr_dl[i]) begin
                    deadline[i] <= PWDATA;
                    arm[i]      <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= S_IDLE;
            idx       <= '0;
            best      <= '0;
            cur       <= '0;
            best_vld  <= 1'b0;
            best_dist <= '0;
            cmp_q     <= '0;
            en_q      <= 1'b0;
        end else if (!gen) begin
            state <= S_IDLE;
            en_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dirty) begin
                        state    <= S_SCAN;
                        idx      <= '0;
                        best_vld <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (scan_cand) begin
                        best_vld  <= 1'b1;
                        best      <= idx;
                        best_dist <= scan_dist;
                    end
                    if (last_idx) begin
                        if (best_vld | scan_cand) begin
                            state <= S_LOAD;
                        end else begin
                            state <= S_IDLE;
                            en_q  <= 1'b0;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_LOAD: begin
                    cmp_q <= deadline[best];
                    en_q  <= 1'b1;
                    cur   <= best;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (TMROV | dirty) begin
                        state    <= S_SCAN;
                        idx      <= '0;
                        best_vld <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        PRDATA = 32'hDEAD_BEEF;
        case (wa)
            18'h0:   PRDATA = {31'd0, gen};
            18'h1:   PRDATA = pre_q;
            18'h2:   PRDATA = {{(32-NCH){1'b0}}, arm};
            18'h3:   PRDATA = {{(32-NCH){1'b0}}, pend};
            18'h4:   PRDATA = {{(32-NCH){1'b0}}, irqen};
            18'h5:   PRDATA = TMR;
            default: ;
        endcase
        for (int i = 0; i < NCH; i++) begin
            if (wa == 18'(16 + i)) PRDATA = deadline[i];
`ifdef TMR32_SCHED_PERIODIC_EN
            if (wa == 18'(32 + i)) PRDATA = period[i];
`endif
        end
    end

    assign PREADY   = 1'b1;
    assign IRQ      = |(pend & irqen);
    assign PRE      = pre_q;
    assign TMRCMP   = cmp_q;
    assign TMREN    = en_q;
    // LOAD drops any overflow left over from the previous compare value.
    assign TMROVCLR = (state == S_LOAD);

endmodule
